// File: rtl/triple_buffer_manager.sv
// triple_buffer_manager
//
// Arbitrates three SDRAM frame-buffer slots between one writer (camera) and one
// reader (composer / HSV fetch). The writer never stalls; at each of its own frame
// boundaries the reader moves to the newest completed frame, if there is one.
//
// Optional statistics: define TRIPLE_BUFFER_STATS_EN to build the drop/repeat
// counters. When it is undefined, the counter ports read 0, clear_stats is ignored,
// and no counter registers are built.
//
// Ports:
//   clk           system clock
//   reset_n       synchronous, active-low reset
//   enable        level; 0 freezes all buffer assignments (vsync edges are consumed)
//   wr_vsync_in   async writer vsync; a rising edge marks a completed frame
//   rd_vsync_in   async reader vsync; a rising edge marks a reader frame boundary
//   write_port    slot the writer fills
//   read_port     slot the reader displays
//   write_swap    one-cycle pulse when write_port changes
//   read_swap     one-cycle pulse when read_port changes
//   fresh         a completed frame is waiting that the reader has not taken
//   clear_stats   one-cycle pulse; zeroes the counters
//   drop_count    frames overwritten before being read (saturating)
//   repeat_count  reader frames that kept the old slot (saturating)
module triple_buffer_manager #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             enable,
  input  logic             wr_vsync_in,
  input  logic             rd_vsync_in,
  output logic [1:0]       write_port,
  output logic [1:0]       read_port,
  output logic             write_swap,
  output logic             read_swap,
  output logic             fresh,
  input  logic             clear_stats,
  output logic [CNT_W-1:0] drop_count,
  output logic [CNT_W-1:0] repeat_count
);

  // Input synchronisers. The history flop follows the last sync stage, so an
  // input held high yields a single edge.
  logic [SYNC_STAGES-1:0] wr_sync_q, rd_sync_q;
  logic                   wr_hist_q, rd_hist_q;
  logic                   wr_edge, rd_edge;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_sync_q <= '0;
      rd_sync_q <= '0;
      wr_hist_q <= 1'b0;
      rd_hist_q <= 1'b0;
    end else begin
      wr_sync_q <= {wr_sync_q[SYNC_STAGES-2:0], wr_vsync_in};
      rd_sync_q <= {rd_sync_q[SYNC_STAGES-2:0], rd_vsync_in};
      wr_hist_q <= wr_sync_q[SYNC_STAGES-1];
      rd_hist_q <= rd_sync_q[SYNC_STAGES-1];
    end
  end

  assign wr_edge = wr_sync_q[SYNC_STAGES-1] & ~wr_hist_q;
  assign rd_edge = rd_sync_q[SYNC_STAGES-1] & ~rd_hist_q;

  // Slot state.
  logic [1:0] w_q, w_d, r_q, r_d, l_q, l_d;
  logic       fresh_q, fresh_d;
  logic       wswap_q, wswap_d, rswap_q, rswap_d;
  logic       drop_ev, repeat_ev;

  always_comb begin
    w_d       = w_q;
    r_d       = r_q;
    l_d       = l_q;
    fresh_d   = fresh_q;
    wswap_d   = 1'b0;
    rswap_d   = 1'b0;
    drop_ev   = 1'b0;
    repeat_ev = 1'b0;
    if (enable) begin
      // Write-done is applied first, so a coincident read takes the frame just
      // completed.
      if (wr_edge) begin
        l_d     = w_q;
        // Slots are distinct values in 0..2, so 3-W-R is the remaining one.
        w_d     = 2'd3 - w_q - r_q;
        fresh_d = 1'b1;
        wswap_d = 1'b1;
        drop_ev = fresh_q;
      end
      if (rd_edge) begin
        if (fresh_d) begin
          r_d     = l_d;
          fresh_d = 1'b0;
          rswap_d = 1'b1;
        end else begin
          repeat_ev = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      w_q     <= 2'd0;
      r_q     <= 2'd1;
      l_q     <= 2'd1;
      fresh_q <= 1'b0;
      wswap_q <= 1'b0;
      rswap_q <= 1'b0;
    end else begin
      w_q     <= w_d;
      r_q     <= r_d;
      l_q     <= l_d;
      fresh_q <= fresh_d;
      wswap_q <= wswap_d;
      rswap_q <= rswap_d;
    end
  end

  assign write_port = w_q;
  assign read_port  = r_q;
  assign fresh      = fresh_q;
  assign write_swap = wswap_q;
  assign read_swap  = rswap_q;

`ifdef TRIPLE_BUFFER_STATS_EN
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [CNT_W-1:0] repeat_cnt_q, repeat_cnt_d;

  always_comb begin
    drop_cnt_d   = drop_cnt_q;
    repeat_cnt_d = repeat_cnt_q;
    if (clear_stats) begin
      drop_cnt_d   = '0;
      repeat_cnt_d = '0;
    end else begin
      if (drop_ev && (drop_cnt_q != '1)) begin
        drop_cnt_d = drop_cnt_q + 1'b1;
      end
      if (repeat_ev && (repeat_cnt_q != '1)) begin
        repeat_cnt_d = repeat_cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      drop_cnt_q   <= '0;
      repeat_cnt_q <= '0;
    end else begin
      drop_cnt_q   <= drop_cnt_d;
      repeat_cnt_q <= repeat_cnt_d;
    end
  end

  assign drop_count   = drop_cnt_q;
  assign repeat_count = repeat_cnt_q;
`else
  logic unused_stats;
  assign unused_stats = clear_stats ^ drop_ev ^ repeat_ev;
  assign drop_count   = '0;
  assign repeat_count = '0;
`endif

  // Slot-ownership invariants.
  always_ff @(posedge clk) begin
    if (reset_n) begin
      assert (w_q != r_q);
      assert (w_q != l_q);
      assert (fresh_q || (l_q == r_q));
    end
  end

endmodule

// File: tb/tb_triple_buffer_manager.sv
module tb_triple_buffer_manager;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        enable;
  logic        wr_vsync_in;
  logic        rd_vsync_in;
  logic [1:0]  write_port;
  logic [1:0]  read_port;
  logic        write_swap;
  logic        read_swap;
  logic        fresh;
  logic        clear_stats;
  logic [15:0] drop_count;
  logic [15:0] repeat_count;

  int checks = 0;
  int errors = 0;
  int ws_cnt = 0;
  int rs_cnt = 0;
  int both_cnt = 0;
  int ws0, rs0, both0;

`ifdef TRIPLE_BUFFER_STATS_EN
  localparam bit Stats = 1'b1;
`else
  localparam bit Stats = 1'b0;
`endif

  triple_buffer_manager #(
    .SYNC_STAGES(2),
    .CNT_W      (16)
  ) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .enable      (enable),
    .wr_vsync_in (wr_vsync_in),
    .rd_vsync_in (rd_vsync_in),
    .write_port  (write_port),
    .read_port   (read_port),
    .write_swap  (write_swap),
    .read_swap   (read_swap),
    .fresh       (fresh),
    .clear_stats (clear_stats),
    .drop_count  (drop_count),
    .repeat_count(repeat_count)
  );

  always #5 clk = ~clk;

  // Count high cycles of each pulse output.
  always @(posedge clk) begin
    if (write_swap) ws_cnt <= ws_cnt + 1;
    if (read_swap) rs_cnt <= rs_cnt + 1;
    if (write_swap && read_swap) both_cnt <= both_cnt + 1;
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic snap();
    ws0   = ws_cnt;
    rs0   = rs_cnt;
    both0 = both_cnt;
  endtask

  task automatic do_reset();
    reset_n     = 1'b0;
    enable      = 1'b1;
    wr_vsync_in = 1'b0;
    rd_vsync_in = 1'b0;
    clear_stats = 1'b0;
    tick(3);
    reset_n = 1'b1;
    tick(1);
  endtask

  // Raise the chosen vsync inputs for a few cycles, then drop them and settle.
  task automatic vs_event(input logic wr, input logic rd);
    wr_vsync_in = wr;
    rd_vsync_in = rd;
    tick(4);
    wr_vsync_in = 1'b0;
    rd_vsync_in = 1'b0;
    tick(4);
  endtask

  initial begin
    do_reset();
    check_eq("rst_w", write_port, 2'd0);
    check_eq("rst_r", read_port, 2'd1);
    check_eq("rst_fresh", fresh, 1'b0);
    check_eq("rst_wswap", write_swap, 1'b0);
    check_eq("rst_rswap", read_swap, 1'b0);
    check_eq("rst_drop", drop_count, 16'd0);
    check_eq("rst_repeat", repeat_count, 16'd0);

    // Single write-done: exact two-edge latency and a one-cycle pulse.
    snap();
    wr_vsync_in = 1'b1;
    tick(1);  // edge N: first sample
    check_eq("lat_n_w", write_port, 2'd0);
    tick(1);  // edge N+1
    check_eq("lat_n1_w", write_port, 2'd0);
    check_eq("lat_n1_wswap", write_swap, 1'b0);
    tick(1);  // edge N+2: update
    check_eq("wr1_w", write_port, 2'd2);
    check_eq("wr1_r", read_port, 2'd1);
    check_eq("wr1_fresh", fresh, 1'b1);
    check_eq("wr1_wswap", write_swap, 1'b1);
    check_eq("wr1_rswap", read_swap, 1'b0);
    tick(1);
    check_eq("wr1_wswap_end", write_swap, 1'b0);
    tick(3);  // input still high: no further pulse
    wr_vsync_in = 1'b0;
    tick(4);
    check_eq("wr1_pulses", ws_cnt - ws0, 1);

    // Read takes the completed frame (L=0).
    snap();
    vs_event(1'b0, 1'b1);
    check_eq("rd1_r", read_port, 2'd0);
    check_eq("rd1_w", write_port, 2'd2);
    check_eq("rd1_fresh", fresh, 1'b0);
    check_eq("rd1_pulses", rs_cnt - rs0, 1);
    check_eq("rd1_wpulses", ws_cnt - ws0, 0);

    // Two writes without a read: the first frame is dropped.
    do_reset();
    vs_event(1'b1, 1'b0);
    check_eq("ww1_w", write_port, 2'd2);
    vs_event(1'b1, 1'b0);
    check_eq("ww2_w", write_port, 2'd0);
    check_eq("ww2_r", read_port, 2'd1);
    check_eq("ww2_fresh", fresh, 1'b1);
    check_eq("ww2_drop", drop_count, Stats ? 16'd1 : 16'd0);
    vs_event(1'b0, 1'b1);
    check_eq("ww2_rd_r", read_port, 2'd2);
    check_eq("ww2_rd_w", write_port, 2'd0);

    // Coincident write and read edges.
    do_reset();
    snap();
    vs_event(1'b1, 1'b1);
    check_eq("sim_r", read_port, 2'd0);
    check_eq("sim_w", write_port, 2'd2);
    check_eq("sim_fresh", fresh, 1'b0);
    check_eq("sim_both", both_cnt - both0, 1);
    check_eq("sim_drop", drop_count, 16'd0);
    check_eq("sim_repeat", repeat_count, 16'd0);

    // Read with nothing fresh: repeat.
    do_reset();
    snap();
    vs_event(1'b0, 1'b1);
    check_eq("rep_r", read_port, 2'd1);
    check_eq("rep_rswap", rs_cnt - rs0, 0);
    check_eq("rep_cnt", repeat_count, Stats ? 16'd1 : 16'd0);
`ifdef TRIPLE_BUFFER_STATS_EN
    force dut.repeat_cnt_q = 16'hffff;
    #1;
    release dut.repeat_cnt_q;
    tick(1);
    vs_event(1'b0, 1'b1);
    check_eq("rep_sat", repeat_count, 16'hffff);
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    check_eq("rep_clear", repeat_count, 16'd0);
`else
    clear_stats = 1'b1;
    tick(1);
    clear_stats = 1'b0;
    check_eq("rep_off_clear", repeat_count, 16'd0);
`endif

    // Disabled: edges consumed, state frozen.
    do_reset();
    snap();
    enable = 1'b0;
    for (int i = 0; i < 3; i++) vs_event(1'b1, 1'b0);
    for (int i = 0; i < 2; i++) vs_event(1'b0, 1'b1);
    check_eq("dis_w", write_port, 2'd0);
    check_eq("dis_r", read_port, 2'd1);
    check_eq("dis_fresh", fresh, 1'b0);
    check_eq("dis_wpulses", ws_cnt - ws0, 0);
    check_eq("dis_rpulses", rs_cnt - rs0, 0);
    check_eq("dis_drop", drop_count, 16'd0);
    check_eq("dis_repeat", repeat_count, 16'd0);
    // Re-enable while writer vsync is held high: no replayed event.
    wr_vsync_in = 1'b1;
    tick(4);
    enable = 1'b1;
    tick(4);
    check_eq("reen_w", write_port, 2'd0);
    check_eq("reen_wpulses", ws_cnt - ws0, 0);
    wr_vsync_in = 1'b0;
    tick(4);
    vs_event(1'b1, 1'b0);
    check_eq("reen_live_w", write_port, 2'd2);

    // Reset mid-event: the pending edge is lost.
    wr_vsync_in = 1'b1;
    tick(1);
    reset_n = 1'b0;
    wr_vsync_in = 1'b0;
    tick(1);
    reset_n = 1'b1;
    tick(4);
    check_eq("midrst_w", write_port, 2'd0);
    check_eq("midrst_fresh", fresh, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
